// File: rtl/image_feeder.sv
// image_feeder: credit-gated pixel streamer from an upstream source into a line-buffer block.
// Ports:
//   i_clk, i_rstn            clock (rising edge), asynchronous active-low reset
//   i_start                  one-cycle pulse that begins a frame (honoured only in IDLE)
//   i_s_data/i_s_valid       upstream pixel stream; o_s_ready accepts it (high only in SEND)
//   o_pixel_data(_valid)     pixel to the line buffer, registered one cycle after the handshake
//   i_intr                   line-consumed pulse from the line buffer, returns one credit
//   o_busy, o_done           frame in progress / one-cycle end-of-frame pulse
// Optional feature: define LINE_FLUSH_EN to append two lines of 0x00 pixels after the last line.
module image_feeder #(
  parameter int LINE_WIDTH   = 512,
  parameter int NUM_LINES    = 512,
  parameter int INIT_CREDITS = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  output logic       o_s_ready,
  output logic [7:0] o_pixel_data,
  output logic       o_pixel_data_valid,
  input  logic       i_intr,
  output logic       o_busy,
  output logic       o_done
);
  localparam int CW  = LINE_WIDTH > 1 ? $clog2(LINE_WIDTH) : 1;
  localparam int LNW = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
  localparam int CRW = $clog2(INIT_CREDITS + 1);
  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_CREDIT,
`ifdef LINE_FLUSH_EN
    FLUSH,
`endif
    DONE
  } state_t;
  state_t         state;
  logic [CW-1:0]  column;
  logic [LNW-1:0] line;
  logic [CRW-1:0] credit;
  logic [CRW-1:0] credit_nxt;
  logic           hs;
  logic           col_end;
  logic           last_line;
  logic           inc;
  logic           dec;
`ifdef LINE_FLUSH_EN
  logic           flush_line;
  logic           flush_emit;
  assign flush_emit = (state == FLUSH) && (credit != '0);
  assign dec        = col_end && (hs || flush_emit);
`else
  assign dec        = hs && col_end;
`endif
  assign o_s_ready = (state == SEND);
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == DONE);
  assign hs        = i_s_valid && o_s_ready;
  assign col_end   = (column == CW'(LINE_WIDTH - 1));
  assign last_line = (line == LNW'(NUM_LINES - 1));
  // A returned credit is dropped only when already full and no line closes this cycle.
  assign inc        = i_intr && (state != IDLE) && (dec || credit != CRW'(INIT_CREDITS));
  assign credit_nxt = credit + CRW'(inc) - CRW'(dec);
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state              <= IDLE;
      column             <= '0;
      line               <= '0;
      credit             <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
`ifdef LINE_FLUSH_EN
      flush_line         <= 1'b0;
`endif
    end else begin
      o_pixel_data_valid <= 1'b0;
      credit             <= credit_nxt;
      case (state)
        IDLE: if (i_start) begin
          credit <= CRW'(INIT_CREDITS);
          column <= '0;
          line   <= '0;
`ifdef LINE_FLUSH_EN
          flush_line <= 1'b0;
`endif
          state  <= SEND;
        end
        SEND: if (hs) begin
          o_pixel_data       <= i_s_data;
          o_pixel_data_valid <= 1'b1;
          column             <= col_end ? '0 : column + CW'(1);
          if (col_end) begin
            line <= last_line ? '0 : line + LNW'(1);
`ifdef LINE_FLUSH_EN
            if (last_line) state <= FLUSH;
`else
            if (last_line) state <= DONE;
`endif
            else if (credit_nxt == '0) state <= WAIT_CREDIT;
          end
        end
        WAIT_CREDIT: if (i_intr) state <= SEND;
`ifdef LINE_FLUSH_EN
        FLUSH: if (flush_emit) begin
          o_pixel_data       <= 8'h00;
          o_pixel_data_valid <= 1'b1;
          column             <= col_end ? '0 : column + CW'(1);
          if (col_end) begin
            flush_line <= ~flush_line;
            if (flush_line) state <= DONE;
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/image_feeder.md
IMAGE_FEEDER -- requirements
Module: image_feeder

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 512, meaning pixels per image line.
REQ-002 SHALL have parameter NUM_LINES, default 512, meaning lines per frame.
REQ-003 SHALL have parameter INIT_CREDITS, default 4, meaning line slots free in the downstream line-buffer block at frame start.
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rstn, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port i_start, input, 1, meaning one-cycle pulse that begins a frame.
REQ-007 SHALL have port i_s_data, input, 8, meaning upstream pixel.
REQ-008 SHALL have port i_s_valid, input, 1, meaning upstream pixel valid.
REQ-009 SHALL have port o_s_ready, output, 1, meaning feeder accepts the upstream pixel this cycle.
REQ-010 SHALL have port o_pixel_data, output, 8, meaning pixel to the line-buffer block.
REQ-011 SHALL have port o_pixel_data_valid, output, 1, meaning o_pixel_data valid this cycle.
REQ-012 SHALL have port i_intr, input, 1, meaning one-cycle pulse from the line-buffer block: one line consumed, one credit returned.
REQ-013 SHALL have port o_busy, output, 1, meaning a frame is in progress.
REQ-014 SHALL have port o_done, output, 1, meaning one-cycle pulse at frame end.

Function
REQ-015 SHALL implement states IDLE, SEND, WAIT_CREDIT, FLUSH, DONE.
REQ-016 IDLE: on i_start SHALL load credit=INIT_CREDITS, column=0, line=0, go to SEND; i_start SHALL be ignored outside IDLE.
REQ-017 o_s_ready SHALL be 1 only in SEND (combinational from state).
REQ-018 Upstream handshake (i_s_valid & o_s_ready) SHALL register i_s_data into o_pixel_data and assert o_pixel_data_valid the next cycle (latency 1); no handshake -> o_pixel_data_valid=0, o_pixel_data holds.
REQ-019 Each handshake SHALL increment column; column LINE_WIDTH-1 wraps to 0 and increments line.
REQ-020 Completing a line SHALL decrement credit; i_intr SHALL increment credit; both in one cycle -> credit unchanged.
REQ-021 i_intr with credit already INIT_CREDITS and no simultaneous line end SHALL be ignored (saturate, no wrap).
REQ-022 After completing line NUM_LINES-1 SHALL go to FLUSH if LINE_FLUSH_EN is defined, else DONE.
REQ-023 After a non-final line, if the resulting credit is 0, SHALL go to WAIT_CREDIT; otherwise SHALL stay in SEND without a bubble.
REQ-024 WAIT_CREDIT: on i_intr SHALL return to SEND the next cycle.
REQ-025 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 Counters SHALL be sized $clog2 of their ranges; credit width $clog2(INIT_CREDITS+1).

Reset
REQ-028 Asserting i_rstn low at any time, including mid-frame, SHALL immediately force state IDLE, credit, column and line to 0, and o_pixel_data=0, o_pixel_data_valid=0, o_busy=0, o_done=0, o_s_ready=0.
REQ-029 After reset release, the first frame SHALL begin only on a new i_start.

Configuration
REQ-030 Macro LINE_FLUSH_EN defined: FLUSH SHALL emit 2 lines of pixel value 0x00 with o_pixel_data_valid=1 each cycle while credit>0, consume a credit per line, stall while credit=0, then go to DONE; upstream is not read in FLUSH.
REQ-031 Macro LINE_FLUSH_EN undefined: FLUSH state and its logic SHALL be absent; frame ends after NUM_LINES lines.

Verification (LINE_WIDTH=4, NUM_LINES=6, INIT_CREDITS=4)
REQ-032 Start, upstream always valid, no i_intr -> 16 pixels out in 16 consecutive cycles, then WAIT_CREDIT with o_s_ready=0.
REQ-033 In WAIT_CREDIT pulse i_intr -> o_s_ready=1 next cycle, 4 more pixels, WAIT_CREDIT again.
REQ-034 i_intr on same cycle as a line's last handshake with credit=1 -> credit stays 1, no stall, next line starts next cycle.
REQ-035 Full frame with i_intr after each line, flush off -> 24 pixels, o_done one cycle, o_busy falls; flush on -> additional 8 zero pixels before o_done.
REQ-036 i_rstn low at pixel 10 -> outputs 0 immediately; i_start after release -> frame restarts at line 0 with credit 4.
REQ-037 i_start pulsed during SEND and i_intr at credit 4 in SEND -> no effect on counters or state.
